// File: rtl/mod12_pkg.sv
// mod12_pkg: shared state type and mod-12 counter constants.
package mod12_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int MOD12_W = 4;
  localparam logic [MOD12_W-1:0] MOD12_MAX = 4'd11;
endpackage

// File: rtl/mod12_run_ctrl_core.sv
// mod12_core: registered mod-12 counter, load has priority over enable, wrap pulses on 11->0.
module mod12_core
  import mod12_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [MOD12_W-1:0] d,
  input  logic               en,
  output logic [MOD12_W-1:0] q,
  output logic               wrap
);
  logic [MOD12_W-1:0] q_q, q_d;
  logic wrap_q, wrap_d;
  always_comb begin
    q_d = ld ? d : en ? (q_q == MOD12_MAX ? '0 : q_q + 1'b1) : q_q;
    wrap_d = !ld && en && q_q == MOD12_MAX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign q = q_q;
  assign wrap = wrap_q;
endmodule

// File: rtl/mod12_run_ctrl.sv
// mod12_run_ctrl: runs a mod-12 counter from start_val for steps advances, one per PRESCALE clocks.
// Optional MOD12_RUN_CTRL_PAUSE_EN adds a pause input that freezes an in-progress run.
module mod12_run_ctrl
  import mod12_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int STEPS_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MOD12_W-1:0] start_val,
  input  logic [STEPS_W-1:0] steps,
`ifdef MOD12_RUN_CTRL_PAUSE_EN
  input  logic               pause,
`endif
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [MOD12_W-1:0] q,
  output logic               wrap
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  state_e state_q;
  logic [PW-1:0] presc_q;
  logic [STEPS_W-1:0] rem_q;
  logic busy_q, done_q, err_q;
  logic pause_w, ld, en;
`ifdef MOD12_RUN_CTRL_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif
  always_comb begin
    ld = state_q == IDLE && start && start_val <= MOD12_MAX;
    en = state_q == RUN && !pause_w && presc_q == PMAX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      rem_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !ld) err_q <= 1'b1;
          if (ld) begin
            rem_q <= steps;
            presc_q <= '0;
            busy_q <= 1'b1;
            state_q <= steps == '0 ? DONE : RUN;
          end
        end
        RUN: begin
          if (en) begin
            presc_q <= '0;
            rem_q <= rem_q - 1'b1;
            if (rem_q == STEPS_W'(1)) state_q <= DONE;
          end else if (!pause_w) begin
            presc_q <= presc_q + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  mod12_core u_core (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .d   (start_val),
    .en  (en),
    .q   (q),
    .wrap(wrap)
  );
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_mod12_run_ctrl.sv
// tb_mod12_run_ctrl: two instances (PRESCALE 1 and 3) on shared stimulus, checked against a run-schedule model.
module tb_mod12_run_ctrl;
  logic clk = 1'b0;
  logic rst, start, pause;
  logic [3:0] start_val;
  logic [7:0] steps;
  logic [1:0] busy, done, err, wrap;
  logic [3:0] q [2];
  int n_tests = 0;
  int n_fail = 0;
  int pre [2] = '{1, 3};
  int ph [2], act [2], mq [2], msv [2], mn [2];
  bit ew [2], ed [2], ee [2];

  always #5 clk = ~clk;

  mod12_run_ctrl #(.PRESCALE(1), .STEPS_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .start_val(start_val), .steps(steps),
`ifdef MOD12_RUN_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy[0]), .done(done[0]), .err(err[0]), .q(q[0]), .wrap(wrap[0])
  );
  mod12_run_ctrl #(.PRESCALE(3), .STEPS_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .start_val(start_val), .steps(steps),
`ifdef MOD12_RUN_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy[1]), .done(done[1]), .err(err[1]), .q(q[1]), .wrap(wrap[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ph: 0 idle, 1 advancing, 2 completion pending; q derives from start value plus elapsed active edges / prescale
  task automatic model_edge(input int d, input bit r, input bit s, input int v, input int n, input bit pz);
    ew[d] = 0; ed[d] = 0; ee[d] = 0;
    if (r) begin
      ph[d] = 0; mq[d] = 0; act[d] = 0;
    end else if (ph[d] == 0) begin
      if (s && v > 11) ee[d] = 1;
      else if (s) begin
        mq[d] = v; msv[d] = v; mn[d] = n; act[d] = 0;
        ph[d] = n == 0 ? 2 : 1;
      end
    end else if (ph[d] == 1) begin
      if (!pz) begin
        act[d]++;
        if (act[d] % pre[d] == 0) begin
          mq[d] = (msv[d] + act[d] / pre[d]) % 12;
          ew[d] = mq[d] == 0;
          if (act[d] / pre[d] == mn[d]) ph[d] = 2;
        end
      end
    end else begin
      ed[d] = 1; ph[d] = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input int v, input int n, input bit pz);
    bit pe;
`ifdef MOD12_RUN_CTRL_PAUSE_EN
    pe = pz;
`else
    pe = 1'b0;
`endif
    rst = r; start = s; start_val = 4'(v); steps = 8'(n); pause = pe;
    for (int d = 0; d < 2; d++) model_edge(d, r, s, v, n, pe);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("q[%0d]", d), 32'(q[d]), 32'(mq[d]));
      check($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(ph[d] != 0));
      check($sformatf("done[%0d]", d), 32'(done[d]), 32'(ed[d]));
      check($sformatf("err[%0d]", d), 32'(err[d]), 32'(ee[d]));
      check($sformatf("wrap[%0d]", d), 32'(wrap[d]), 32'(ew[d]));
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; start = 0; start_val = 0; steps = 0; pause = 0;
    step(1, 1, 9, 5, 0);
    step(1, 1, 9, 5, 0);
    step(0, 1, 9, 5, 0);
    idle(20);
    step(0, 1, 12, 3, 0);
    idle(3);
    step(0, 1, 7, 0, 0);
    idle(4);
    step(0, 1, 3, 10, 0);
    idle(3);
    step(0, 1, 0, 5, 0);
    idle(2);
    step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 11, 2, 0);
    idle(2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    idle(12);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 13),
           $urandom_range(0, 7) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 14),
           $urandom_range(0, 3) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
